// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } acc_state_t;

  function automatic int unsigned nchunks(input int unsigned acc_w, input int unsigned chunk);
    return acc_w / chunk;
  endfunction

endpackage

// File: rtl/csa_row.sv
// Row of N independent 3:2 compressors; carry_o is pre-shifted (carry_o[0] is always 0).
module csa_row #(
  parameter int unsigned N = 68
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] sum_o,
  output logic [N:0]   carry_o
);

  always_comb begin
    sum_o      = a_i ^ b_i ^ c_i;
    carry_o    = '0;
    carry_o[N:1] = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule

// File: rtl/csa_stream_accumulator.sv
// Accumulates a packet of operands in carry-save form, then resolves the total
// with a CHUNK-bit ripple of the final carry-propagate add, one chunk per cycle.
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned G     = 4,
  parameter int unsigned CHUNK = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+G-1:0] out_data,
  output logic           out_ovf
);

  localparam int unsigned ACC_W = W + G;
  localparam int unsigned NCH   = nchunks(ACC_W, CHUNK);
  localparam int unsigned KW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW    = G + 1;
  localparam logic [CW-1:0] CNT_SAT = CW'(2 ** G + 1);
  localparam logic [CW-1:0] CNT_OVF = CW'(2 ** G);

  if ((ACC_W % CHUNK) != 0) begin : g_bad_chunk
    $error("csa_stream_accumulator: ACC_W must be a multiple of CHUNK");
  end

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] s_q, c_q, res_q, res_d, out_q;
  logic [CW-1:0]    cnt_q;
  logic [KW-1:0]    k_q;
  logic             cy_q, ovf_q;

  logic             beat, last_chunk;
  logic [ACC_W-1:0] x, row_sum;
  logic [ACC_W:0]   row_carry;
  logic [CHUNK:0]   chunk_sum;
  logic             unused_carry_out;

  assign x                = {{G{1'b0}}, in_data};
  assign in_ready         = ((state_q == IDLE) || (state_q == ACCUM)) && rst_n;
  assign beat             = in_valid && in_ready;
  assign last_chunk       = (k_q == KW'(NCH - 1));
  assign unused_carry_out = row_carry[ACC_W];

  assign out_valid = (state_q == OUTPUT);
  assign out_data  = out_q;
  assign out_ovf   = ovf_q;

  csa_row #(
    .N(ACC_W)
  ) u_row (
    .a_i    (s_q),
    .b_i    (c_q),
    .c_i    (x),
    .sum_o  (row_sum),
    .carry_o(row_carry)
  );

  always_comb begin
    chunk_sum = {1'b0, s_q[k_q*CHUNK +: CHUNK]} + {1'b0, c_q[k_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cy_q};
    res_d = res_q;
    res_d[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: if (beat) state_d = in_last ? RESOLVE : ACCUM;
      RESOLVE:     if (last_chunk) state_d = OUTPUT;
      OUTPUT:      if (out_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (beat) begin
            s_q   <= x;
            c_q   <= '0;
            cnt_q <= CW'(1);
          end
        end
        ACCUM: begin
          if (beat) begin
            s_q <= row_sum;
            c_q <= row_carry[ACC_W-1:0];
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CW'(1);
          end
        end
        RESOLVE: begin
          res_q <= res_d;
          cy_q  <= chunk_sum[CHUNK];
          k_q   <= k_q + KW'(1);
          // Publish only a fully resolved word so out_data holds the previous result meanwhile.
          if (last_chunk) begin
            out_q <= res_d;
            ovf_q <= (cnt_q > CNT_OVF);
          end
        end
        OUTPUT: ;
      endcase
      if (beat && in_last) begin
        k_q  <= '0;
        cy_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops them on each output transfer.
module tb_csa_stream_accumulator;

  localparam int unsigned W     = 64;
  localparam int unsigned G     = 4;
  localparam int unsigned ACC_W = W + G;

  typedef struct {
    logic [ACC_W-1:0] d;
    logic             o;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last;
  logic [W-1:0]     in_data;
  logic             out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0] out_data;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  localparam logic [W-1:0] ONES = {W{1'b1}};

  csa_stream_accumulator #(
    .W(W),
    .G(G),
    .CHUNK(17)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [ACC_W-1:0] d, input logic o);
    exp_t e;
    e.d = d;
    e.o = o;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat is accepted.
  task automatic send_beat(input logic [W-1:0] d, input logic last, input int gap);
    int n;
    bit ok;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL beat_accept: got no in_ready within %0d cycles, required acceptance", n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) begin
      n_checks++;
      $display("FAIL %s_done: got pending=%0d in_ready=%0b, required drained and ready",
               name, exp_q.size(), in_ready);
    end
  endtask

  // Monitor: one comparison set per output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got out_data=%0h with no result pending", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_ovf", out_ovf, e.o);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bad;
    logic [ACC_W-1:0] hold_exp;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset behaviour
    @(negedge clk);
    check("rst_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_in_ready_held", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 1: single beat, latency
    push_exp(68'd5, 1'b0);
    send_beat(64'd5, 1'b1, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_latency", n, 5);
    wait_done("t1");

    // 2: three all-ones beats
    push_exp(68'h2_FFFF_FFFF_FFFF_FFFD, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(ONES, i == 2, 0);
    wait_done("t2");

    // 3: seventeen then sixteen all-ones beats
    push_exp(68'h0_FFFF_FFFF_FFFF_FFEF, 1'b1);
    for (int i = 0; i < 17; i++) send_beat(ONES, i == 16, 0);
    wait_done("t3a");
    push_exp(68'hF_FFFF_FFFF_FFFF_FFF0, 1'b0);
    for (int i = 0; i < 16; i++) send_beat(ONES, i == 15, 0);
    wait_done("t3b");

    // 4: output backpressure
    hold_exp  = 68'h1234_5678;
    out_ready = 1'b0;
    push_exp(hold_exp, 1'b0);
    send_beat(64'h1234_5678, 1'b1, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_valid_seen", out_valid, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (!(out_valid === 1'b1 && out_data === hold_exp && out_ovf === 1'b0 && in_ready === 1'b0))
        bad++;
    end
    check("t4_hold_stable_cycles_bad", bad, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_in_ready_after", in_ready, 1'b1);
    check("t4_valid_dropped", out_valid, 1'b0);
    check("t4_data_kept", out_data, hold_exp);
    wait_done("t4");

    // 5: gaps between beats, then the gap-free run
    push_exp(68'd10, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(64'(i + 1), i == 3, i);
    wait_done("t5gap");
    push_exp(68'd10, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(64'(i + 1), i == 3, 0);
    wait_done("t5flat");

    // 6: reset during RESOLVE abandons the packet
    send_beat(64'd99, 1'b1, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_in_ready_in_rst", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_out_data", out_data, '0);
    check("t6_out_ovf", out_ovf, 1'b0);
    check("t6_in_ready", in_ready, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("t6_no_output_cycles", bad, 0);
    @(posedge clk);
    #1;
    push_exp(68'd15, 1'b0);
    send_beat(64'd7, 1'b0, 0);
    send_beat(64'd8, 1'b1, 0);
    wait_done("t6");

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
